// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Opcode, FSM state and stack geometry constants shared by the
//               CPU datapath and stack sequencing logic.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALL2 = 2'd1;
    localparam logic [1:0] ST_RET2  = 2'd2;

    localparam logic [7:0] STACK_TOP_DEF   = 8'hFF;
    localparam int         STACK_DEPTH_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : stack_unit
// Description : Stack pointer / sequencer in front of data memory for PUSH,
//               POP and two-cycle CALL/RET, with sticky overflow/underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] STACK_TOP   = STACK_TOP_DEF,
    parameter int         STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] op,
    input  logic [7:0] push_data,
    input  logic [7:0] pc_next,
    input  logic [7:0] call_target,
    input  logic [7:0] flags_in,
    input  logic [7:0] mem_rdata,
    output logic [7:0] sp_addr,
    output logic [7:0] sp_wdata,
    output logic       sp_w,
    output logic [7:0] pop_data,
    output logic       reg_load,
    output logic       pc_load,
    output logic [7:0] pc_target,
    output logic       flags_load,
    output logic [7:0] flags_out,
    output logic       stall,
    output logic [7:0] sp,
    output logic       ovf,
    output logic       unf
);

    localparam logic [7:0] C_DEPTH = 8'(STACK_DEPTH);

    logic [7:0] r_sp;
    logic [7:0] r_count;
    logic [1:0] r_state;
    logic       r_ovf;
    logic       r_unf;

    logic [1:0] w_state_nxt;
    logic       w_sp_dec;
    logic       w_sp_inc;
    logic       w_set_ovf;
    logic       w_set_unf;
    logic [7:0] w_sp_plus1;
    logic       w_call_full;

    assign w_sp_plus1  = r_sp + 8'd1;
    // CALL needs room for two bytes; 9-bit compare avoids DEPTH-2 wrapping.
    assign w_call_full = ({1'b0, r_count} + 9'd2) > {1'b0, C_DEPTH};

    assign sp  = r_sp;
    assign ovf = r_ovf;
    assign unf = r_unf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sp    <= STACK_TOP;
            r_count <= 8'd0;
            r_state <= ST_IDLE;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sp_dec) begin
                r_sp    <= r_sp - 8'd1;
                r_count <= r_count + 8'd1;
            end else if (w_sp_inc) begin
                r_sp    <= w_sp_plus1;
                r_count <= r_count - 8'd1;
            end
            if (w_set_ovf) r_ovf <= 1'b1;
            if (w_set_unf) r_unf <= 1'b1;
        end
    end

    always_comb begin
        sp_addr     = 8'd0;
        sp_wdata    = 8'd0;
        sp_w        = 1'b0;
        pop_data    = 8'd0;
        reg_load    = 1'b0;
        pc_load     = 1'b0;
        pc_target   = 8'd0;
        flags_load  = 1'b0;
        flags_out   = 8'd0;
        stall       = 1'b0;
        w_state_nxt = r_state;
        w_sp_dec    = 1'b0;
        w_sp_inc    = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;

        if (rst_n) begin
            case (r_state)
                ST_CALL2: begin
                    sp_addr     = r_sp;
                    sp_wdata    = flags_in;
                    sp_w        = 1'b1;
                    pc_load     = 1'b1;
                    pc_target   = call_target;
                    w_sp_dec    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_RET2: begin
                    sp_addr     = w_sp_plus1;
                    pc_target   = mem_rdata;
                    pc_load     = 1'b1;
                    w_sp_inc    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    case (op)
                        OP_PUSH: begin
                            sp_addr  = r_sp;
                            sp_wdata = push_data;
                            if (r_count == C_DEPTH) begin
                                w_set_ovf = 1'b1;
                            end else begin
                                sp_w     = 1'b1;
                                w_sp_dec = 1'b1;
                            end
                        end
                        OP_POP: begin
                            sp_addr = w_sp_plus1;
                            if (r_count == 8'd0) begin
                                w_set_unf = 1'b1;
                            end else begin
                                pop_data = mem_rdata;
                                reg_load = 1'b1;
                                w_sp_inc = 1'b1;
                            end
                        end
                        OP_CALL: begin
                            if (w_call_full) begin
                                w_set_ovf = 1'b1;
                            end else begin
                                sp_addr     = r_sp;
                                sp_wdata    = pc_next;
                                sp_w        = 1'b1;
                                stall       = 1'b1;
                                w_sp_dec    = 1'b1;
                                w_state_nxt = ST_CALL2;
                            end
                        end
                        OP_RET: begin
                            if (r_count < 8'd2) begin
                                w_set_unf = 1'b1;
                            end else begin
                                sp_addr     = w_sp_plus1;
                                flags_out   = mem_rdata;
                                flags_load  = 1'b1;
                                stall       = 1'b1;
                                w_sp_inc    = 1'b1;
                                w_state_nxt = ST_RET2;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_unit
// Description : Scoreboard bench for stack_unit against a queue-based stack
//               model, with a behavioural data memory attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_unit;

    localparam logic [7:0] STACK_TOP   = 8'hFF;
    localparam int         STACK_DEPTH = 16;

    typedef struct packed {
        logic [7:0] sp_addr;
        logic [7:0] sp_wdata;
        logic       sp_w;
        logic [7:0] pop_data;
        logic       reg_load;
        logic       pc_load;
        logic [7:0] pc_target;
        logic       flags_load;
        logic [7:0] flags_out;
        logic       stall;
        logic [7:0] sp;
        logic       ovf;
        logic       unf;
    } obs_t;

    typedef struct {
        obs_t o;
        bit   chk_addr;
        int   cyc;
    } exp_t;

    logic       clk = 1'b1;
    logic       rst_n;
    logic [2:0] op;
    logic [7:0] push_data, pc_next, call_target, flags_in, mem_rdata;
    logic [7:0] sp_addr, sp_wdata, pop_data, pc_target, flags_out, sp;
    logic       sp_w, reg_load, pc_load, flags_load, stall, ovf, unf;

    logic [7:0] tb_mem [256];
    exp_t       sb [$];
    int         compared = 0;
    int         errors   = 0;
    int         cyc      = 0;

    // Behavioural model: stack contents as a queue, top at the back.
    logic [7:0] m_stack [$];
    int         m_phase;
    logic [7:0] m_ovf, m_unf;

    always #5 clk = ~clk;

    stack_unit #(.STACK_TOP(STACK_TOP), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .push_data(push_data),
        .pc_next(pc_next), .call_target(call_target), .flags_in(flags_in),
        .mem_rdata(mem_rdata), .sp_addr(sp_addr), .sp_wdata(sp_wdata),
        .sp_w(sp_w), .pop_data(pop_data), .reg_load(reg_load),
        .pc_load(pc_load), .pc_target(pc_target), .flags_load(flags_load),
        .flags_out(flags_out), .stall(stall), .sp(sp), .ovf(ovf), .unf(unf)
    );

    assign mem_rdata = tb_mem[sp_addr];
    always @(posedge clk) if (sp_w) tb_mem[sp_addr] <= sp_wdata;

    task automatic model_step(input logic [2:0] o, input logic [7:0] pd,
                              input logic [7:0] pcn, input logic [7:0] ct,
                              input logic [7:0] fl, input logic rv,
                              output exp_t e);
        logic [7:0] sp_cur;
        int n;
        n = m_stack.size();
        sp_cur = 8'(int'(STACK_TOP) - n);
        e.o = '0;
        e.o.sp = sp_cur;
        e.o.ovf = m_ovf[0];
        e.o.unf = m_unf[0];
        e.chk_addr = 1'b1;
        e.cyc = cyc;
        if (!rv) begin
            m_stack.delete();
            m_phase = 0;
            m_ovf = 8'd0;
            m_unf = 8'd0;
            return;
        end
        if (m_phase == 1) begin
            e.o.sp_addr = sp_cur; e.o.sp_wdata = fl; e.o.sp_w = 1'b1;
            e.o.pc_load = 1'b1; e.o.pc_target = ct;
            m_stack.push_back(fl);
            m_phase = 0;
        end else if (m_phase == 2) begin
            e.o.sp_addr = sp_cur + 8'd1; e.o.pc_load = 1'b1;
            e.o.pc_target = m_stack.pop_back();
            m_phase = 0;
        end else begin
            case (o)
                3'd1: if (n == STACK_DEPTH) begin
                        m_ovf = 8'd1; e.chk_addr = 1'b0;
                    end else begin
                        e.o.sp_addr = sp_cur; e.o.sp_wdata = pd; e.o.sp_w = 1'b1;
                        m_stack.push_back(pd);
                    end
                3'd2: if (n == 0) begin
                        m_unf = 8'd1; e.chk_addr = 1'b0;
                    end else begin
                        e.o.sp_addr = sp_cur + 8'd1; e.o.reg_load = 1'b1;
                        e.o.pop_data = m_stack.pop_back();
                    end
                3'd3: if (n + 2 > STACK_DEPTH) begin
                        m_ovf = 8'd1; e.chk_addr = 1'b0;
                    end else begin
                        e.o.sp_addr = sp_cur; e.o.sp_wdata = pcn; e.o.sp_w = 1'b1;
                        e.o.stall = 1'b1;
                        m_stack.push_back(pcn);
                        m_phase = 1;
                    end
                3'd4: if (n < 2) begin
                        m_unf = 8'd1; e.chk_addr = 1'b0;
                    end else begin
                        e.o.sp_addr = sp_cur + 8'd1; e.o.flags_load = 1'b1;
                        e.o.stall = 1'b1;
                        e.o.flags_out = m_stack.pop_back();
                        m_phase = 2;
                    end
                default: ;
            endcase
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] pd,
                         input logic [7:0] pcn, input logic [7:0] ct,
                         input logic [7:0] fl, input logic rv);
        exp_t e;
        op = o; push_data = pd; pc_next = pcn; call_target = ct;
        flags_in = fl; rst_n = rv;
        model_step(o, pd, pcn, ct, fl, rv, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_op(input int bias);
        logic [2:0] o;
        int r;
        r = $urandom_range(0, 99);
        if (r < bias)            o = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd3;
        else if (r < bias + 40)  o = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd4;
        else                     o = 3'($urandom_range(0, 7));
        issue(o, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 79) != 0));
    endtask

    // Monitor: one expected entry per cycle, checked mid-cycle.
    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a.sp_addr = sp_addr;   a.sp_wdata = sp_wdata; a.sp_w = sp_w;
                a.pop_data = pop_data; a.reg_load = reg_load; a.pc_load = pc_load;
                a.pc_target = pc_target; a.flags_load = flags_load;
                a.flags_out = flags_out; a.stall = stall; a.sp = sp;
                a.ovf = ovf; a.unf = unf;
                if (!e.chk_addr) begin
                    a.sp_addr  = e.o.sp_addr;
                    a.sp_wdata = e.o.sp_wdata;
                end
                compared++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL cycle %0d outputs: actual %h required %h (addr %h/%h sp %h/%h)",
                             e.cyc, a, e.o, sp_addr, e.o.sp_addr, sp, e.o.sp);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'd0;
        m_phase = 0; m_ovf = 8'd0; m_unf = 8'd0;
        rst_n = 1'b0; op = 3'd0; push_data = 8'd0; pc_next = 8'd0;
        call_target = 8'd0; flags_in = 8'd0;
        @(posedge clk);
        #1;

        issue(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        issue(3'd1, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(3'd3, 8'h00, 8'h12, 8'h40, 8'h03, 1'b1);
        issue(3'd2, 8'h00, 8'h12, 8'h40, 8'h03, 1'b1);
        issue(3'd4, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 17; i++) issue(3'd1, 8'(i + 8'hA0), 8'h00, 8'h00, 8'h00, 1'b1);
        issue(3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(3'd3, 8'h00, 8'h21, 8'h30, 8'h07, 1'b1);
        for (int i = 0; i < 16; i++) issue(3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(3'd1, 8'h77, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(3'd4, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(3'd7, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        issue(3'd3, 8'h00, 8'h55, 8'h66, 8'h01, 1'b1);
        issue(3'd0, 8'h00, 8'h55, 8'h66, 8'h01, 1'b0);
        issue(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

        for (int i = 0; i < 300; i++) rand_op(45);
        for (int i = 0; i < 300; i++) rand_op(20);
        for (int i = 0; i < 300; i++) rand_op(50);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            compared++;
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Stack-pointer and sequencing stage directly upstream of data memory.
- Drives the stack-path address, write data and write enable into the data-memory address mux for PUSH, POP, CALL and RET.
- Consumes the asynchronous memory read data to return popped bytes, restored flags and return PCs to the datapath and PC.
- Keeps the stack pointer and occupancy count, detects overflow and underflow, and stalls the control unit during two-cycle CALL and RET.

Parameters:
- STACK_TOP, 8'hFF, address of the first slot used. The stack grows downward.
- STACK_DEPTH, 16, maximum number of bytes on the stack (1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- op  in  3  operation: 0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET; 5-7 behave as NOP.
- push_data  in  8  byte to push (regA/ALU).
- pc_next  in  8  return address pushed by CALL.
- call_target  in  8  jump destination for CALL.
- flags_in  in  8  status byte pushed by CALL.
- mem_rdata  in  8  data-memory read data (asynchronous read).
- sp_addr  out  8  stack address to the data-memory address mux.
- sp_wdata  out  8  write data to data memory.
- sp_w  out  1  write enable to data memory.
- pop_data  out  8  popped byte for the register file.
- reg_load  out  1  pop_data valid this cycle.
- pc_load  out  1  load pc_target into PC.
- pc_target  out  8  new PC value.
- flags_load  out  1  load flags_out into the status register.
- flags_out  out  8  restored flags.
- stall  out  1  control unit must hold op and PC.
- sp  out  8  current stack pointer (debug).
- ovf  out  1  sticky overflow.
- unf  out  1  sticky underflow.

Behaviour:
- State registers: sp (8b), count (0..STACK_DEPTH), FSM {IDLE, CALL2, RET2}, ovf, unf.
- Empty stack: sp = STACK_TOP, count = 0.
- Reset (rst_n=0 at a clock edge): sp<=STACK_TOP, count<=0, FSM<=IDLE, ovf<=0, unf<=0. Reset has priority over any operation in progress, including CALL2/RET2; the pending second write or load is dropped.
- All combinational outputs default to 0 (including sp_addr, sp_wdata, pop_data, pc_target, flags_out) in IDLE with op=NOP and during reset.
- Addressing:
  - Push writes mem[sp], then sp<=sp-1, count+1.
  - Pop reads mem[sp+1] combinationally from mem_rdata in the same cycle, then sp<=sp+1, count-1.
  - All address arithmetic is modulo 256.
- PUSH (IDLE), 1 cycle:
  - Outputs: sp_addr=sp, sp_wdata=push_data, sp_w=1.
  - If count==STACK_DEPTH: sp_w=0, no state change, ovf<=1.
- POP (IDLE), 1 cycle:
  - Outputs: sp_addr=sp+1, pop_data=mem_rdata, reg_load=1.
  - If count==0: reg_load=0, pop_data=0, no state change, unf<=1.
- CALL, 2 cycles:
  - Cycle 1 (IDLE): sp_addr=sp, sp_wdata=pc_next, sp_w=1, stall=1; sp--, count++; FSM<=CALL2.
  - Cycle 2 (CALL2): sp_addr=sp, sp_wdata=flags_in, sp_w=1, pc_load=1, pc_target=call_target, stall=0; sp--, count++; FSM<=IDLE.
  - If count > STACK_DEPTH-2 in cycle 1: whole CALL aborted (no write, no pc_load, stall=0, stays IDLE), ovf<=1.
- RET, 2 cycles:
  - Cycle 1 (IDLE): sp_addr=sp+1, flags_out=mem_rdata, flags_load=1, stall=1; sp++, count--; FSM<=RET2.
  - Cycle 2 (RET2): sp_addr=sp+1, pc_target=mem_rdata, pc_load=1; sp++, count--; FSM<=IDLE.
  - If count<2 in cycle 1: whole RET aborted (no loads, no state change), unf<=1.
- In CALL2/RET2, op is ignored; the second phase always completes.
- Single-cycle ops may be issued back-to-back every cycle. PUSH then POP in consecutive cycles returns the pushed byte.
- ovf and unf clear only on reset.

Decomposition:
- Shared package cpu_pkg:
  - op encodings (OP_NOP..OP_RET).
  - FSM state encoding.
  - STACK_TOP and STACK_DEPTH defaults.
- No sub-module. A single module with one sequential block and one combinational output block.

Test Plan:
- After reset: sp=0xFF, count=0, all outputs 0. PUSH 0x5A -> sp_addr=0xFF, sp_w=1; next cycle sp=0xFE. POP -> sp_addr=0xFF, reg_load=1, pop_data=0x5A, sp=0xFF.
- CALL with pc_next=0x12, flags_in=0x03, call_target=0x40:
  - Cycle 1: write 0x12@0xFF, stall=1.
  - Cycle 2: write 0x03@0xFE, pc_load=1, pc_target=0x40.
  - Result: sp=0xFD.
- Following RET:
  - Cycle 1: flags_load=1, flags_out=0x03.
  - Cycle 2: pc_load=1, pc_target=0x12.
  - Result: sp=0xFF.
- 16 PUSHes, then a 17th PUSH -> sp_w=0, sp stays 0xEF, ovf=1. With 15 on the stack, CALL -> aborted, ovf=1, no pc_load.
- POP on empty -> reg_load=0, unf=1, sp=0xFF. RET with 1 byte on the stack -> aborted, unf=1.
- Reset asserted during CALL2 -> no second write, no pc_load, sp=0xFF, FSM=IDLE on the next cycle.
